// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I datapath with a shared memory, one ALU and one register file.
// Sequences fetch/decode/execute, handles variable-latency memory and counts retired instructions.
module multicycle_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             adr_src,
    output logic             mem_read_en,
    output logic             mem_write_en,
    output logic             reg_write_en,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             illegal_instr,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] instr_retired
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] FETCH     = 4'd1;
    localparam logic [3:0] DECODE    = 4'd2;
    localparam logic [3:0] MEM_ADR   = 4'd3;
    localparam logic [3:0] MEM_READ  = 4'd4;
    localparam logic [3:0] MEM_WB    = 4'd5;
    localparam logic [3:0] MEM_WRITE = 4'd6;
    localparam logic [3:0] EXEC_R    = 4'd7;
    localparam logic [3:0] EXEC_I    = 4'd8;
    localparam logic [3:0] ALU_WB    = 4'd9;
    localparam logic [3:0] BRANCH    = 4'd10;
    localparam logic [3:0] JAL       = 4'd11;
    localparam logic [3:0] HALT      = 4'd12;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             illegal_q;
    logic             retire;

    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        adr_src      = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        reg_write_en = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        result_src   = 2'b00;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_read_en = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                // Precompute old PC + imm so BRANCH/JAL find the target ready.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEM_ADR;
                    OP_R:              state_d = EXEC_R;
                    OP_I:              state_d = EXEC_I;
                    OP_BRANCH:         state_d = (funct3 == 3'b000 || funct3 == 3'b001) ?
                                                 BRANCH : HALT;
                    OP_JAL:            state_d = JAL;
                    default:           state_d = HALT;
                endcase
            end
            MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                adr_src     = 1'b1;
                mem_read_en = 1'b1;
                if (mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                result_src   = 2'b01;
                reg_write_en = 1'b1;
                retire       = 1'b1;
                state_d      = FETCH;
            end
            MEM_WRITE: begin
                adr_src      = 1'b1;
                mem_write_en = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_write_en = 1'b1;
                retire       = 1'b1;
                state_d      = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = (funct3 == 3'b000) ? zero : ~zero;
                retire    = 1'b1;
                state_d   = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALU_WB;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
            if (state_d == HALT) illegal_q <= 1'b1;
        end
    end

    assign illegal_instr = illegal_q;
    assign state_dbg     = state_q;
    assign instr_retired = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed plus randomized instruction stream
// compared against an instruction-level reference model.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, adr_src, mem_read_en, mem_write_en, reg_write_en;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic        illegal_instr;
    logic [3:0]  state_dbg;
    logic [31:0] instr_retired;
    logic [14:0] dut_vec;

    // Narrow-counter instance for the wrap check.
    logic        reset4 = 1'b0;
    logic [6:0]  opcode4 = 7'b0110011;
    logic [2:0]  funct3_4 = 3'd0;
    logic        zero4 = 1'b0;
    logic        ready4 = 1'b1;
    logic        pcw4, irw4, adr4, rd4, wr4, rw4, ill4;
    logic [1:0]  a4, b4, op4, rs4;
    logic [3:0]  state4;
    logic [3:0]  cnt4;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_cnt = 32'd0;

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .reg_write_en(reg_write_en),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .illegal_instr(illegal_instr), .state_dbg(state_dbg),
        .instr_retired(instr_retired)
    );

    multicycle_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset4), .opcode(opcode4), .funct3(funct3_4), .zero(zero4),
        .mem_ready(ready4), .pc_write(pcw4), .ir_write(irw4), .adr_src(adr4),
        .mem_read_en(rd4), .mem_write_en(wr4), .reg_write_en(rw4),
        .alu_src_a(a4), .alu_src_b(b4), .alu_op(op4), .result_src(rs4),
        .illegal_instr(ill4), .state_dbg(state4), .instr_retired(cnt4)
    );

    assign dut_vec = {pc_write, ir_write, adr_src, mem_read_en, mem_write_en, reg_write_en,
                      alu_src_a, alu_src_b, alu_op, result_src, illegal_instr};

    // Output table for each state, packed in the same field order as dut_vec.
    function automatic logic [14:0] spec_out(int st, logic rdy, logic z, logic [2:0] f3,
                                             logic ill);
        logic pcw, irw, adr, rd, wr, rw;
        logic [1:0] a, b, op, rs;
        pcw = 0; irw = 0; adr = 0; rd = 0; wr = 0; rw = 0;
        a = 0; b = 0; op = 0; rs = 0;
        case (st)
            1:  begin rd = 1; b = 2'b10; rs = 2'b10; pcw = rdy; irw = rdy; end
            2:  begin a = 2'b01; b = 2'b01; end
            3:  begin a = 2'b10; b = 2'b01; end
            4:  begin adr = 1; rd = 1; end
            5:  begin rs = 2'b01; rw = 1; end
            6:  begin adr = 1; wr = 1; end
            7:  begin a = 2'b10; op = 2'b10; end
            8:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
            9:  rw = 1;
            10: begin a = 2'b10; op = 2'b01; pcw = (f3 == 3'b000) ? z : !z; end
            11: begin a = 2'b01; b = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {pcw, irw, adr, rd, wr, rw, a, b, op, rs, ill};
    endfunction

    function automatic logic [6:0] opc(int cls);
        case (cls)
            0: return 7'b0110011;
            1: return 7'b0010011;
            2: return 7'b0000011;
            3: return 7'b0100011;
            4: return 7'b1100011;
            default: return 7'b1101111;
        endcase
    endfunction

    function automatic logic rb(bit noise);
        return noise ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs just after the falling edge, check, advance to the next one.
    task automatic step(int st, logic rdy, logic z, logic ill, string tag);
        mem_ready = rdy;
        zero = z;
        #1;
        chk({tag, "/state"}, 32'(state_dbg), 32'(st));
        chk({tag, "/outs"}, 32'(dut_vec), 32'(spec_out(st, rdy, z, funct3, ill)));
        @(negedge clk);
    endtask

    // Expected state trace of one instruction derived from its class and memory latencies.
    task automatic run_instr(int cls, logic [2:0] f3, logic z, int flat, int mlat, bit noise);
        opcode = opc(cls);
        funct3 = f3;
        for (int i = 0; i < flat; i++) step(1, 1'b0, rb(noise), 1'b0, "fetch_wait");
        step(1, 1'b1, rb(noise), 1'b0, "fetch");
        step(2, rb(noise), rb(noise), 1'b0, "decode");
        case (cls)
            0: begin step(7, rb(noise), rb(noise), 1'b0, "exec_r");
                     step(9, rb(noise), rb(noise), 1'b0, "alu_wb"); end
            1: begin step(8, rb(noise), rb(noise), 1'b0, "exec_i");
                     step(9, rb(noise), rb(noise), 1'b0, "alu_wb"); end
            2: begin
                step(3, rb(noise), rb(noise), 1'b0, "mem_adr");
                for (int i = 0; i < mlat; i++) step(4, 1'b0, rb(noise), 1'b0, "mem_read_w");
                step(4, 1'b1, rb(noise), 1'b0, "mem_read");
                step(5, rb(noise), rb(noise), 1'b0, "mem_wb");
            end
            3: begin
                step(3, rb(noise), rb(noise), 1'b0, "mem_adr");
                for (int i = 0; i < mlat; i++) step(6, 1'b0, rb(noise), 1'b0, "mem_write_w");
                step(6, 1'b1, rb(noise), 1'b0, "mem_write");
            end
            4: step(10, rb(noise), z, 1'b0, "branch");
            default: begin step(11, rb(noise), rb(noise), 1'b0, "jal");
                           step(9, rb(noise), rb(noise), 1'b0, "alu_wb"); end
        endcase
        model_cnt = model_cnt + 32'd1;
        chk("retired", instr_retired, model_cnt);
    endtask

    task automatic run_illegal(logic [6:0] op, logic [2:0] f3);
        opcode = op;
        funct3 = f3;
        step(1, 1'b1, 1'b0, 1'b0, "ill_fetch");
        step(2, 1'b1, 1'b0, 1'b0, "ill_decode");
        for (int i = 0; i < 20; i++)
            step(12, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, "halt");
        chk("halt_retired", instr_retired, model_cnt);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        model_cnt = 32'd0;
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_outs", 32'(dut_vec), 32'(spec_out(0, mem_ready, zero, funct3, 1'b0)));
        chk("rst_cnt", instr_retired, model_cnt);
        reset = 1'b1;
        #1;
        chk("idle_state", 32'(state_dbg), 32'd0);
        chk("idle_outs", 32'(dut_vec), 32'(spec_out(0, mem_ready, zero, funct3, 1'b0)));
        @(negedge clk);
    endtask

    initial begin
        do_reset();

        // Directed: add, stalled load, three branches.
        run_instr(0, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(2, 3'b010, 1'b0, 0, 3, 1'b0);
        run_instr(4, 3'b000, 1'b1, 0, 0, 1'b0);
        run_instr(4, 3'b000, 1'b0, 0, 0, 1'b0);
        run_instr(4, 3'b001, 1'b0, 0, 0, 1'b0);

        // Randomized instruction stream with random latencies and ignored-input noise.
        for (int n = 0; n < 60; n++) begin
            int cls;
            cls = int'($urandom_range(0, 5));
            run_instr(cls, (cls == 4) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset asserted in the middle of a stalled store.
        opcode = opc(3);
        step(1, 1'b1, 1'b0, 1'b0, "st_fetch");
        step(2, 1'b1, 1'b0, 1'b0, "st_decode");
        step(3, 1'b1, 1'b0, 1'b0, "st_adr");
        mem_ready = 1'b0;
        #1;
        chk("stall_wr_en", 32'(mem_write_en), 32'd1);
        chk("stall_cnt", instr_retired, model_cnt);
        #2;
        reset = 1'b0;
        #1;
        model_cnt = 32'd0;
        chk("async_wr_en", 32'(mem_write_en), 32'd0);
        chk("async_state", 32'(state_dbg), 32'd0);
        chk("async_cnt", instr_retired, model_cnt);
        @(negedge clk);
        do_reset();

        run_instr(1, 3'b000, 1'b0, 1, 0, 1'b1);
        run_illegal(7'b1111111, 3'b000);
        do_reset();
        run_illegal(7'b1100011, 3'b010);

        // 4-bit counter: back-to-back R-type, 4 cycles each after one IDLE cycle.
        reset4 = 1'b1;
        repeat (61) @(negedge clk);
        chk("cnt4_full", 32'(cnt4), 32'((60 / 4) % 16));
        repeat (4) @(negedge clk);
        chk("cnt4_wrap", 32'(cnt4), 32'((64 / 4) % 16));
        chk("cnt4_state", 32'(state4), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy FSM that sequences a multicycle RV32I datapath: one shared instruction/data memory, one ALU, one register file, each used in successive cycles.
- Decodes the latched instruction's opcode and funct3, and drives all mux selects and enables per cycle.
- Supports a variable-latency memory through a ready handshake.
- Provides a retired-instruction counter and an illegal-instruction halt.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward.
- funct3  in  3  instr[14:12] from the instruction register.
- zero  in  1  ALU zero flag (combinational, current cycle).
- mem_ready  in  1  memory completes the access this cycle.
- pc_write  out  1  PC register load enable.
- ir_write  out  1  instruction register load enable.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
- mem_read_en  out  1  memory read request.
- mem_write_en  out  1  memory write request.
- reg_write_en  out  1  register-file write enable.
- alu_src_a  out  2  operand A select: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b  out  2  operand B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- alu_op  out  2  ALU control: 00 = add, 01 = subtract/compare, 10 = decode funct fields.
- result_src  out  2  result select: 00 = ALU result register, 01 = memory data, 10 = live ALU output.
- illegal_instr  out  1  sticky flag; set on an undecodable instruction.
- state_dbg  out  4  current state encoding.
- instr_retired  out  CNT_W  count of retired instructions.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC_R=7, EXEC_I=8, ALU_WB=9, BRANCH=10, JAL=11, HALT=12.
- Defaults: every output not listed for a state is 0.
- Reset (reset=0, asynchronous): state=IDLE, instr_retired=0, illegal_instr=0, all other outputs 0.
- IDLE: all outputs 0; next state FETCH unconditionally.
- FETCH:
  - Drives adr_src=0, mem_read_en=1, a=00, b=10, op=00, result_src=10.
  - While mem_ready=0: hold the state and all outputs.
  - When mem_ready=1: ir_write=1 and pc_write=1 in that same cycle (Mealy), then go to DECODE.
- DECODE:
  - Drives a=01, b=01, op=00 (precomputes the branch/jump target).
  - Next state by opcode:
    - 0000011 or 0100011 -> MEM_ADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH if funct3 is 000 or 001, else HALT
    - 1101111 -> JAL
    - any other opcode -> HALT
- MEM_ADR: a=10, b=01, op=00; next is MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ: adr_src=1, mem_read_en=1; hold until mem_ready=1, then MEM_WB.
- MEM_WB: result_src=01, reg_write_en=1; then FETCH; counts as a retire.
- MEM_WRITE: adr_src=1, mem_write_en=1; hold until mem_ready=1, then FETCH; retires in the mem_ready cycle.
- EXEC_R: a=10, b=00, op=10; then ALU_WB.
- EXEC_I: a=10, b=01, op=10; then ALU_WB.
- ALU_WB: result_src=00, reg_write_en=1; then FETCH; retire.
- BRANCH:
  - Drives a=10, b=00, op=01, result_src=00.
  - pc_write = zero when funct3=000 (beq); pc_write = ~zero when funct3=001 (bne).
  - Next state FETCH; retire.
- JAL: a=01, b=10, op=00 (computes link = old PC + 4), result_src=00, pc_write=1; then ALU_WB, which writes the link and retires.
- HALT:
  - illegal_instr=1 from the first HALT cycle onward; no enables asserted.
  - Remains in HALT until reset.
  - instr_retired does not count the illegal instruction.
- Retire counter:
  - Increments by exactly 1 on the clock edge that leaves a retiring state.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
- At most one of mem_read_en and mem_write_en is ever 1.
- Reset asserted mid-access: state returns to IDLE immediately and all enables drop in the same cycle, with no waiting for mem_ready.

Test Plan:
- Reset sequence: hold reset=0 for 3 cycles, release -> IDLE for 1 cycle, then FETCH with mem_read_en=1, adr_src=0, instr_retired=0.
- Add with mem_ready tied to 1, opcode=0110011 -> state sequence FETCH, DECODE, EXEC_R, ALU_WB, FETCH; reg_write_en=1 only in ALU_WB; instr_retired=1.
- Load with mem_ready=0 for 3 cycles in MEM_READ -> MEM_READ held 4 cycles with adr_src=1 and mem_read_en=1; MEM_WB asserts result_src=01 and reg_write_en=1; instruction takes 8 cycles total.
- Branches:
  - beq with zero=1 -> pc_write=1 in BRANCH.
  - beq with zero=0 -> pc_write=0.
  - bne with zero=0 -> pc_write=1.
  - All three end in FETCH and increment the counter.
- Illegal instructions: opcode=1111111, or branch with funct3=010 -> HALT; illegal_instr=1 and held; no enables for 20 cycles; counter unchanged.
- Reset during a MEM_WRITE stall -> mem_write_en falls asynchronously; state=IDLE; counter=0. Separately, preload the counter to all-ones with CNT_W=4 and retire once -> counter reads 0.
